// File: rtl/bst_mem_arbiter.sv
// Round-robin arbiter sharing the BST memory-driver port between insert, search and delete engines.
// Read requester IDs are queued so read data is routed back in issue order.
module bst_mem_arbiter #(
    parameter int NB_REQ         = 3,
    parameter int RAM_ADDR_WIDTH = 16,
    parameter int RAM_DATA_WIDTH = 32,
    parameter int OSTDG_DEPTH    = 4
) (
    input  logic                               aclk,
    input  logic                               srst,
    input  logic [NB_REQ-1:0]                  req_valid,
    output logic [NB_REQ-1:0]                  req_ready,
    input  logic [NB_REQ-1:0]                  req_rd,
    input  logic [NB_REQ-1:0]                  req_wr,
    input  logic [NB_REQ*RAM_ADDR_WIDTH-1:0]   req_addr,
    input  logic [NB_REQ*RAM_DATA_WIDTH-1:0]   req_wr_data,
    output logic [NB_REQ-1:0]                  rsp_valid,
    input  logic [NB_REQ-1:0]                  rsp_ready,
    output logic [RAM_DATA_WIDTH-1:0]          rsp_data,
    output logic                               mem_valid,
    input  logic                               mem_ready,
    output logic                               mem_rd,
    output logic                               mem_wr,
    output logic [RAM_ADDR_WIDTH-1:0]          mem_addr,
    output logic [RAM_DATA_WIDTH-1:0]          mem_wr_data,
    input  logic                               mem_rd_valid,
    output logic                               mem_rd_ready,
    input  logic [RAM_DATA_WIDTH-1:0]          mem_rd_data,
    output logic [$clog2(OSTDG_DEPTH):0]       ostdg_cnt,
    output logic                               err_unexp_rsp
);
    localparam int IDW = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;
    localparam int PW  = $clog2(OSTDG_DEPTH);
    localparam int CW  = PW + 1;

    typedef enum logic {ST_IDLE, ST_ISSUE} state_t;

    state_t                    r_state;
    state_t                    w_state_next;
    logic [IDW-1:0]            r_grant;
    logic [IDW-1:0]            r_last_grant;
    logic [IDW-1:0]            w_pick;
    logic                      w_found;
    logic [NB_REQ-1:0]         w_elig;
    logic [IDW-1:0]            w_cand  [NB_REQ];
    logic [RAM_ADDR_WIDTH-1:0] w_addr  [NB_REQ];
    logic [RAM_DATA_WIDTH-1:0] w_wdata [NB_REQ];

    logic [IDW-1:0]            r_fifo [OSTDG_DEPTH];
    logic [PW-1:0]             r_wptr;
    logic [PW-1:0]             r_rptr;
    logic [CW-1:0]             r_cnt;
    logic                      r_err;
    logic                      w_full;
    logic                      w_empty;
    logic                      w_accept;
    logic                      w_push;
    logic                      w_pop;
    logic [IDW-1:0]            w_head;

    assign w_full   = (r_cnt == CW'(OSTDG_DEPTH));
    assign w_empty  = (r_cnt == '0);
    // The ID queue is only a few entries deep and its head must steer responses in the same cycle.
    assign w_head   = r_fifo[r_rptr];
    assign w_accept = (r_state == ST_ISSUE) && mem_ready;
    assign w_push   = w_accept && req_rd[r_grant];
    assign w_pop    = !w_empty && mem_rd_valid && rsp_ready[w_head];

    genvar gi;
    generate
        for (gi = 0; gi < NB_REQ; gi++) begin : g_req
            assign w_elig[gi]    = req_valid[gi] && (!req_rd[gi] || !w_full);
            // Candidate gi is the requester searched gi-th, starting just after the last grant.
            assign w_cand[gi]    = IDW'((32'(r_last_grant) + 32'(gi) + 32'd1) % 32'(NB_REQ));
            assign w_addr[gi]    = req_addr[gi*RAM_ADDR_WIDTH +: RAM_ADDR_WIDTH];
            assign w_wdata[gi]   = req_wr_data[gi*RAM_DATA_WIDTH +: RAM_DATA_WIDTH];
            assign req_ready[gi] = w_accept && (r_grant == IDW'(gi));
            assign rsp_valid[gi] = !w_empty && mem_rd_valid && (w_head == IDW'(gi));
        end
    endgenerate

    always_comb begin
        w_found = 1'b0;
        w_pick  = r_last_grant;
        for (int k = NB_REQ - 1; k >= 0; k--) begin
            if (w_elig[w_cand[k]]) begin
                w_found = 1'b1;
                w_pick  = w_cand[k];
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (srst) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_last_grant <= IDW'(NB_REQ - 1);
        end else begin
            r_state <= w_state_next;
            if (r_state == ST_IDLE && w_found)
                r_grant <= w_pick;
            if (w_accept)
                r_last_grant <= r_grant;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_found)   w_state_next = ST_ISSUE;
            ST_ISSUE: if (mem_ready) w_state_next = ST_IDLE;
            default:                 w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_valid   = 1'b0;
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = '0;
        mem_wr_data = '0;
        if (r_state == ST_ISSUE) begin
            mem_valid   = 1'b1;
            mem_rd      = req_rd[r_grant];
            mem_wr      = req_wr[r_grant];
            mem_addr    = w_addr[r_grant];
            mem_wr_data = w_wdata[r_grant];
        end
    end

    always_ff @(posedge aclk) begin
        if (w_push)
            r_fifo[r_wptr] <= r_grant;
    end

    always_ff @(posedge aclk) begin
        if (srst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
            r_err  <= 1'b0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + PW'(1);
            if (w_pop)
                r_rptr <= r_rptr + PW'(1);
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
            if (w_empty && mem_rd_valid)
                r_err <= 1'b1;
        end
    end

    assign mem_rd_ready  = !w_empty && rsp_ready[w_head];
    assign rsp_data      = mem_rd_data;
    assign ostdg_cnt     = r_cnt;
    assign err_unexp_rsp = r_err;

endmodule
